time_set_ctrl: RTL and testbench

User-input side of the digital clock: debounces three raw pushbuttons and runs a small edit state machine so an operator can set hours and minutes. On commit it issues a one-cycle load strobe with the new hour/minute value, which the hour/minute counters take as a synchronous load. It also tells the display multiplexer which digit pair to blink while editing.

---
 rtl/time_set_ctrl_pkg.sv | 17 +
 rtl/time_set_ctrl_btn_debounce.sv | 54 +++++
 rtl/time_set_ctrl.sv | 161 ++++++++++++++++
 tb/tb_time_set_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/time_set_ctrl_pkg.sv
// Shared types and limits for the clock time-set controller.
package time_set_ctrl_pkg;

    localparam int unsigned HR_W  = 5;
    localparam int unsigned MIN_W = 6;

    localparam logic [HR_W-1:0]  MAX_HR  = HR_W'(23);
    localparam logic [MIN_W-1:0] MAX_MIN = MIN_W'(59);

    // Encodings double as the set_mode output value.
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2
    } state_e;

endpackage

// File: rtl/time_set_ctrl_btn_debounce.sv
// Raw pushbutton conditioner: 2-FF synchronizer, stable-level debounce, press pulse.
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int unsigned CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

    logic             sync_q1;
    logic             sync_q2;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
        end
    end

    // Accept the synced level only after it has differed for DB_CYCLES cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync_q2 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
            level <= sync_q2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_d <= 1'b0;
            press   <= 1'b0;
        end else begin
            level_d <= level;
            press   <= level & ~level_d;
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Hour/minute edit controller with debounced buttons and commit strobe.
// Optional blink masking is enabled by defining TIME_SET_BLINK_EN.
module time_set_ctrl
    import time_set_ctrl_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 2_000_000,
    parameter int unsigned BLINK_BIT = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_mode,
    input  logic             btn_inc,
    input  logic             btn_dec,
    input  logic [HR_W-1:0]  cur_hr,
    input  logic [MIN_W-1:0] cur_min,
    output logic             load,
    output logic [HR_W-1:0]  load_hr,
    output logic [MIN_W-1:0] load_min,
    output logic [1:0]       set_mode,
    output logic [3:0]       blank_mask
);

    if (BLINK_BIT > 31) begin : g_blink_bit_range
        $error("BLINK_BIT must select a bit of the 32-bit blink counter");
    end

    logic press_mode;
    logic press_inc;
    logic press_dec;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
        .clk(clk), .reset(reset), .btn(btn_mode), .press(press_mode)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
        .clk(clk), .reset(reset), .btn(btn_inc), .press(press_inc)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dec (
        .clk(clk), .reset(reset), .btn(btn_dec), .press(press_dec)
    );

    state_e           state;
    state_e           state_nxt;
    logic [HR_W-1:0]  edit_hr;
    logic [HR_W-1:0]  edit_hr_nxt;
    logic [MIN_W-1:0] edit_min;
    logic [MIN_W-1:0] edit_min_nxt;
    logic             load_nxt;
    logic [HR_W-1:0]  load_hr_nxt;
    logic [MIN_W-1:0] load_min_nxt;
    logic             inc_only;
    logic             dec_only;

    assign inc_only = press_inc & ~press_dec;
    assign dec_only = press_dec & ~press_inc;
    assign set_mode = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_RUN:     if (press_mode) state_nxt = ST_SET_HR;
            ST_SET_HR:  if (press_mode) state_nxt = ST_SET_MIN;
            ST_SET_MIN: if (press_mode) state_nxt = ST_RUN;
            default:    state_nxt = ST_RUN;
        endcase
    end

    // Edit datapath and commit; a mode press wins over any inc/dec in the same cycle.
    always_comb begin
        edit_hr_nxt  = edit_hr;
        edit_min_nxt = edit_min;
        load_nxt     = 1'b0;
        load_hr_nxt  = load_hr;
        load_min_nxt = load_min;
        unique case (state)
            ST_RUN: begin
                if (press_mode) begin
                    edit_hr_nxt  = (cur_hr > MAX_HR) ? '0 : cur_hr;
                    edit_min_nxt = (cur_min > MAX_MIN) ? '0 : cur_min;
                end
            end
            ST_SET_HR: begin
                if (!press_mode) begin
                    if (inc_only) begin
                        edit_hr_nxt = (edit_hr == MAX_HR) ? '0 : edit_hr + HR_W'(1);
                    end else if (dec_only) begin
                        edit_hr_nxt = (edit_hr == '0) ? MAX_HR : edit_hr - HR_W'(1);
                    end
                end
            end
            ST_SET_MIN: begin
                if (press_mode) begin
                    load_nxt     = 1'b1;
                    load_hr_nxt  = edit_hr;
                    load_min_nxt = edit_min;
                end else if (inc_only) begin
                    edit_min_nxt = (edit_min == MAX_MIN) ? '0 : edit_min + MIN_W'(1);
                end else if (dec_only) begin
                    edit_min_nxt = (edit_min == '0) ? MAX_MIN : edit_min - MIN_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edit_hr  <= '0;
            edit_min <= '0;
            load     <= 1'b0;
            load_hr  <= '0;
            load_min <= '0;
        end else begin
            edit_hr  <= edit_hr_nxt;
            edit_min <= edit_min_nxt;
            load     <= load_nxt;
            load_hr  <= load_hr_nxt;
            load_min <= load_min_nxt;
        end
    end

`ifdef TIME_SET_BLINK_EN
    logic [31:0] blink_cnt;
    logic [31:0] blink_nxt;
    logic [3:0]  blank_nxt;

    assign blink_nxt = blink_cnt + 32'd1;

    // Mask is computed from next-cycle counter/state so it lines up with set_mode.
    always_comb begin
        blank_nxt = 4'b0000;
        if (blink_nxt[BLINK_BIT]) begin
            unique case (state_nxt)
                ST_SET_HR:  blank_nxt = 4'b1100;
                ST_SET_MIN: blank_nxt = 4'b0011;
                default:    blank_nxt = 4'b0000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt  <= '0;
            blank_mask <= '0;
        end else begin
            blink_cnt  <= blink_nxt;
            blank_mask <= blank_nxt;
        end
    end
`else
    assign blank_mask = 4'b0000;
`endif

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: behavioural model plus directed scenarios.
module tb_time_set_ctrl;

    localparam int DB = 4;
    localparam int BB = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] btn = 3'b000;     // [0]=mode [1]=inc [2]=dec
    logic [4:0] cur_hr = 5'd22;
    logic [5:0] cur_min = 6'd58;
    logic       load;
    logic [4:0] load_hr;
    logic [5:0] load_min;
    logic [1:0] set_mode;
    logic [3:0] blank_mask;

    int checks = 0;
    int failures = 0;

    // Observed commit history (DUT side)
    int load_seen = 0;
    int last_hr = -1;
    int last_min = -1;
    int last_mode_at_load = -1;

    time_set_ctrl #(.DB_CYCLES(DB), .BLINK_BIT(BB)) dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn[0]), .btn_inc(btn[1]), .btn_dec(btn[2]),
        .cur_hr(cur_hr), .cur_min(cur_min),
        .load(load), .load_hr(load_hr), .load_min(load_min),
        .set_mode(set_mode), .blank_mask(blank_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] hist [3];    // raw samples, [i] = sample from i+1 edges ago
    bit          acc  [3];
    bit [1:0]    pipe [3];
    int          m_mode, m_hr, m_min, m_load, m_lhr, m_lmin, ecount;

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            hist[b] = '0; acc[b] = 1'b0; pipe[b] = '0;
        end
        m_mode = 0; m_hr = 0; m_min = 0; m_load = 0; m_lhr = 0; m_lmin = 0; ecount = 0;
    endtask

    task automatic model_step(input logic [2:0] raw, input int ch, input int cm);
        bit p [3];
        for (int b = 0; b < 3; b++) begin
            bit differ = 1'b1;
            bit rose = 1'b0;
            // synchronizer delays by two samples; need DB consecutive differing samples
            for (int i = 1; i <= DB; i++) if (hist[b][i] == acc[b]) differ = 1'b0;
            if (differ) begin
                acc[b] = ~acc[b];
                rose = acc[b];
            end
            p[b] = pipe[b][1];
            pipe[b] = {pipe[b][0], rose};
            hist[b] = {hist[b][14:0], raw[b]};
        end
        m_load = 0;
        case (m_mode)
            0: if (p[0]) begin
                m_mode = 1;
                m_hr = (ch > 23) ? 0 : ch;
                m_min = (cm > 59) ? 0 : cm;
            end
            1: if (p[0]) m_mode = 2;
               else if (p[1] && !p[2]) m_hr = (m_hr + 1) % 24;
               else if (p[2] && !p[1]) m_hr = (m_hr + 23) % 24;
            default: if (p[0]) begin
                m_mode = 0; m_load = 1; m_lhr = m_hr; m_lmin = m_min;
            end else if (p[1] && !p[2]) m_min = (m_min + 1) % 60;
            else if (p[2] && !p[1]) m_min = (m_min + 59) % 60;
        endcase
        ecount++;
    endtask

    function automatic int exp_blank();
`ifdef TIME_SET_BLINK_EN
        if (((ecount >> BB) & 1) == 0) return 0;
        return (m_mode == 1) ? 12 : (m_mode == 2) ? 3 : 0;
`else
        return 0;
`endif
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!reset) model_reset();
            else model_step(btn, int'(cur_hr), int'(cur_min));
            #1;
            check("set_mode", int'(set_mode), m_mode);
            check("load", int'(load), m_load);
            check("load_hr", int'(load_hr), m_lhr);
            check("load_min", int'(load_min), m_lmin);
            check("blank_mask", int'(blank_mask), exp_blank());
            if (load) begin
                load_seen++;
                last_hr = int'(load_hr);
                last_min = int'(load_min);
                last_mode_at_load = int'(set_mode);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tap(input logic [2:0] mask, input int hold);
        @(negedge clk);
        btn = mask;
        cycles(hold);
        btn = 3'b000;
        cycles(12);
    endtask

    task automatic expect_commit(input string name, input int n, input int hr, input int mn);
        check({name, "_count"}, load_seen, n);
        check({name, "_hr"}, last_hr, hr);
        check({name, "_min"}, last_min, mn);
        check({name, "_mode"}, last_mode_at_load, 0);
    endtask

    initial begin
        cycles(3);
        check("reset_mode", int'(set_mode), 0);
        check("reset_load", int'(load), 0);
        check("reset_load_hr", int'(load_hr), 0);
        reset = 1'b1;
        cycles(3);

        // full set with glitch rejection: 22:58 -> +2h, +3m -> 00:01
        tap(3'b001, 10);
        check("enter_set_hr", int'(set_mode), 1);
        tap(3'b010, 3);                       // glitch, must be ignored
        tap(3'b010, 10);
        tap(3'b010, 10);
        tap(3'b001, 10);
        check("enter_set_min", int'(set_mode), 2);
        tap(3'b010, 10);
        tap(3'b010, 10);
        tap(3'b010, 10);
        check("no_load_yet", load_seen, 0);
        tap(3'b001, 10);
        expect_commit("full_set", 1, 0, 1);

        // wrap down from 00:00, then inc+dec together is a no-op
        cur_hr = 5'd0; cur_min = 6'd0;
        tap(3'b001, 10);
        tap(3'b100, 10);
        tap(3'b001, 10);
        tap(3'b100, 10);
        tap(3'b110, 10);
        tap(3'b001, 10);
        expect_commit("wrap_down", 2, 23, 59);

        // mode+inc together in SET_HR: mode wins, hour unchanged
        cur_hr = 5'd10; cur_min = 6'd20;
        tap(3'b001, 10);
        tap(3'b011, 10);
        check("mode_inc_state", int'(set_mode), 2);
        tap(3'b001, 10);
        expect_commit("mode_inc", 3, 10, 20);

        // reset mid-edit discards edit without load
        tap(3'b001, 10);
        tap(3'b001, 10);
        tap(3'b010, 10);
        @(negedge clk); reset = 1'b0;
        cycles(3);
        check("mid_reset_mode", int'(set_mode), 0);
        reset = 1'b1;
        cycles(10);
        check("mid_reset_noload", load_seen, 3);

        // out-of-range capture clears hour
        cur_hr = 5'd27; cur_min = 6'd5;
        tap(3'b001, 10);
        tap(3'b001, 10);
        tap(3'b001, 10);
        expect_commit("range", 4, 0, 5);

        // button held through reset is a fresh press after release
        @(negedge clk); reset = 1'b0; btn = 3'b001;
        cycles(3);
        reset = 1'b1;
        cycles(12);
        check("held_reset_mode", int'(set_mode), 1);
        btn = 3'b000;
        cycles(12);
        tap(3'b001, 10);
        tap(3'b001, 10);
        expect_commit("held_reset", 5, 0, 5);

        cycles(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
